// File: rtl/ehgu_clksw_ctrl.sv
// Clock-switch sequencer driving the select of the glitch-free clock mux.
// Handshakes a request, quiesces the consumer, flips sel, then waits out the settle window.
module ehgu_clksw_ctrl #(
   parameter logic RESET_SEL       = 1'b0,
   parameter int   SETTLE_CYCLES   = 8,
   parameter int   QUIESCE_TIMEOUT = 64,
   parameter int   CNT_W           = 8
) (
   input  logic clk,
   input  logic rstn,
   input  logic req_valid,
   input  logic req_sel,
   output logic req_ready,
   output logic quiesce_req,
   input  logic quiesce_ack,
   output logic sel,
   output logic busy,
   output logic done,
   output logic err
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_QUIESCE,
      S_SETTLE
   } state_e;

   localparam bit             TO_EN       = (QUIESCE_TIMEOUT != 0);
   localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(QUIESCE_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] SET_LAST  = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   state_e           state_q, state_d;
   logic             sel_q, sel_d;
   logic             tgt_q, tgt_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             qreq_q, qreq_d;
   logic             busy_q, busy_d;
   logic             rdy_q, rdy_d;
   logic             done_q, done_d;
   logic             err_q, err_d;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= S_IDLE;
         sel_q   <= RESET_SEL;
         tgt_q   <= RESET_SEL;
         cnt_q   <= '0;
         qreq_q  <= 1'b0;
         busy_q  <= 1'b0;
         rdy_q   <= 1'b1;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         tgt_q   <= tgt_d;
         cnt_q   <= cnt_d;
         qreq_q  <= qreq_d;
         busy_q  <= busy_d;
         rdy_q   <= rdy_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      tgt_d   = tgt_q;
      cnt_d   = cnt_q;
      qreq_d  = qreq_q;
      busy_d  = busy_q;
      rdy_d   = rdy_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (req_valid && rdy_q) begin
               if (req_sel == sel_q) begin
                  done_d = 1'b1;
               end else begin
                  tgt_d   = req_sel;
                  state_d = S_QUIESCE;
                  qreq_d  = 1'b1;
                  busy_d  = 1'b1;
                  rdy_d   = 1'b0;
                  cnt_d   = '0;
               end
            end
         end
         S_QUIESCE: begin
            // an ack on the timeout edge still wins
            if (quiesce_ack) begin
               sel_d   = tgt_q;
               cnt_d   = '0;
               state_d = S_SETTLE;
            end else if (TO_EN && cnt_q == TO_LAST) begin
               err_d   = 1'b1;
               qreq_d  = 1'b0;
               busy_d  = 1'b0;
               rdy_d   = 1'b1;
               cnt_d   = '0;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         S_SETTLE: begin
            if (cnt_q == SET_LAST) begin
               done_d  = 1'b1;
               qreq_d  = 1'b0;
               busy_d  = 1'b0;
               rdy_d   = 1'b1;
               cnt_d   = '0;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign req_ready   = rdy_q;
   assign quiesce_req = qreq_q;
   assign sel         = sel_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign err         = err_q;

endmodule

// File: doc/ehgu_clksw_ctrl.md
Name: ehgu_clksw_ctrl

Overview:
- Clock-switch sequencer that generates the `sel` input of the glitch-free clock mux (ehgu_clkmux).
- Runs on an always-on reference clock.
- Accepts a switch request over a valid/ready handshake and asks the downstream logic to quiesce.
- Flips `sel` once quiesced, holds for a settle window covering the mux synchroniser stages, then reports completion or a quiesce timeout.

Parameters:
- RESET_SEL, 1'b0, value of `sel` out of reset (0 = clkin0, 1 = clkin1).
- SETTLE_CYCLES, 8, clk cycles to wait after `sel` changes before `done`; must be >=1 and cover both mux sync chains.
- QUIESCE_TIMEOUT, 64, max clk cycles to wait for `quiesce_ack`; 0 disables the timeout.
- CNT_W, 8, width of the internal cycle counter; must hold max(SETTLE_CYCLES, QUIESCE_TIMEOUT).

Ports:
- clk  in  1  always-on reference clock.
- rstn  in  1  reset, synchronous, active-low.
- req_valid  in  1  switch request valid.
- req_sel  in  1  requested clock source.
- req_ready  out  1  controller can accept a request.
- quiesce_req  out  1  ask the consumer of clkout to stop or idle.
- quiesce_ack  in  1  consumer is quiescent; level, sampled on clk.
- sel  out  1  registered select to the clock mux.
- busy  out  1  switch sequence in progress.
- done  out  1  one-cycle pulse: request completed.
- err  out  1  one-cycle pulse: quiesce timeout, request aborted.

Behaviour:
- One clock; reset is synchronous and active-low (clk, rstn).
- Reset values (edge with rstn=0):
  - state=IDLE, sel=RESET_SEL, req_ready=1, quiesce_req=0, busy=0, done=0, err=0, counter=0.
  - Reset mid-sequence aborts it: `sel` returns to RESET_SEL immediately and no done/err is issued. The mux handles the select change glitch-free.
- All outputs are registered. done and err default to 0 each cycle.
- States: IDLE, QUIESCE, SETTLE.
- IDLE:
  - req_ready=1. A request is accepted at edge T0 where req_valid&req_ready=1.
  - If req_sel==sel: no switch. done=1 for the cycle after T0; stay IDLE; quiesce_req stays 0.
  - Else: latch target=req_sel. State goes to QUIESCE, quiesce_req=1, busy=1, req_ready=0, counter=0.
- QUIESCE:
  - On an edge with quiesce_ack=1: sel<=target, counter<=0, go to SETTLE. quiesce_req stays 1.
  - On an edge with quiesce_ack=0: counter increments.
  - Timeout: if QUIESCE_TIMEOUT!=0 and counter==QUIESCE_TIMEOUT-1 with ack=0, then err=1 (one cycle), quiesce_req<=0, busy<=0, req_ready<=1, go to IDLE. sel is unchanged.
  - An ack on the same edge as the timeout wins; no err is raised.
  - An ack already high at entry takes effect at edge T0+1, so sel changes at T0+1.
- SETTLE:
  - Counter increments each edge. quiesce_ack is ignored, including deassertion.
  - At the edge where counter==SETTLE_CYCLES-1: done=1 (one cycle), quiesce_req<=0, busy<=0, req_ready<=1, go to IDLE.
  - sel change edge Ts → done high after edge Ts+SETTLE_CYCLES.
- Handshake rules:
  - req_valid is ignored while req_ready=0; the requester holds req_valid/req_sel until accepted.
  - Back-to-back: a new request may be accepted on the cycle done is high (ready=1 then).
- Exactly one of done/err per accepted request. Never both, never both in the same cycle.
- sel changes at most once per accepted request, and only in the QUIESCE→SETTLE transition.

Test Plan:
- Reset with RESET_SEL=0 → sel=0, req_ready=1, busy=0, quiesce_req=0, done=err=0; hold reset 3 cycles mid-SETTLE → sel back to 0, no done.
- req_sel=1 accepted at T0, quiesce_ack rises at T0+5 → sel=1 at T0+5 edge, done pulse after edge T0+5+8, quiesce_req low with done, busy high T0+1..T0+13.
- req_sel=0 while sel=0 → done one cycle later, quiesce_req never asserts, sel stays 0.
- quiesce_ack held 0, QUIESCE_TIMEOUT=64 → err single pulse after edge T0+64, sel unchanged, req_ready=1, no done.
- Ack coincident with timeout edge → switch proceeds, no err; ack dropping during SETTLE → sequence still completes.
- req_valid held high with alternating req_sel across 4 requests, ack tied 1 → each accepted only when ready, sel toggles 4 times, 4 done pulses, ack-to-sel latency 1 cycle each.
